// File: rtl/risc18_prog_loader.sv
// Program-side sequencer for the RISC18 core: packs streamed 16-bit instructions
// into the core program word, runs the core for a fixed window and returns its result.
module risc18_prog_loader #(
    parameter int unsigned SLOTS      = 4,
    parameter int unsigned RUN_CYCLES = 4,
    parameter logic [15:0] PAD_WORD   = 16'h0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_instr,
    input  logic                  in_last,
    output logic [16*SLOTS-1:0]   core_pc,
    output logic                  core_reset,
    input  logic [15:0]           core_ans,
    input  logic [16*SLOTS-1:0]   core_k,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [15:0]           res_ans,
    output logic [16*SLOTS-1:0]   res_k,
    output logic                  res_err
);

    localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RUN_CYCLES - 1);
    localparam logic [16*SLOTS-1:0] PAD_ALL = {SLOTS{PAD_WORD}};

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        CORE_RST = 2'd1,
        RUN      = 2'd2,
        RESULT   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [16*SLOTS-1:0]   pc_q, pc_d;
    logic [15:0]           ans_q, ans_d;
    logic [16*SLOTS-1:0]   k_q, k_d;
    logic                  err_q, err_d;
    logic                  finish;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            idx_q   <= '0;
            cnt_q   <= '0;
            pc_q    <= PAD_ALL;
            ans_q   <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ans_q   <= ans_d;
            k_q     <= k_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        ans_d   = ans_q;
        k_d     = k_q;
        err_d   = err_q;
        finish  = in_last || (idx_q == LAST_IDX);

        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    // The accepted word and the padding of every later slot land on the same edge.
                    for (int unsigned s = 0; s < SLOTS; s++) begin
                        if (IDX_W'(s) == idx_q) begin
                            pc_d[16*(SLOTS-s)-1 -: 16] = in_instr;
                        end else if (finish && (IDX_W'(s) > idx_q)) begin
                            pc_d[16*(SLOTS-s)-1 -: 16] = PAD_WORD;
                        end
                    end
                    if (finish) begin
                        idx_d   = '0;
                        state_d = CORE_RST;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            CORE_RST: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    ans_d   = core_ans;
                    k_d     = core_k;
                    err_d   = (core_k != pc_q);
                    state_d = RESULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESULT: begin
                if (res_ready) begin
                    pc_d    = PAD_ALL;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    assign in_ready   = (state_q == LOAD);
    assign res_valid  = (state_q == RESULT);
    assign core_reset = (state_q != RUN);
    assign core_pc    = pc_q;
    assign res_ans    = ans_q;
    assign res_k      = k_q;
    assign res_err    = err_q;

endmodule

// File: tb/tb_risc18_prog_loader.sv
// Scoreboard bench for risc18_prog_loader: a free-running counter stands in for core ans,
// and core k is the expected program word optionally corrupted by a mask.
module tb_risc18_prog_loader;

    localparam int unsigned SLOTS = 4;
    localparam int unsigned RC    = 4;
    localparam logic [15:0] PAD   = 16'h0000;
    localparam logic [63:0] PAD_ALL = {SLOTS{PAD}};

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        in_last;
    logic [63:0] core_pc;
    logic        core_reset;
    logic [15:0] core_ans;
    logic [63:0] core_k;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_ans;
    logic [63:0] res_k;
    logic        res_err;

    logic [15:0] cyc;

    typedef struct {
        logic [15:0] ans;
        logic [63:0] k;
        logic        err;
    } res_t;

    res_t sb[$];
    int   n_tests;
    int   n_fail;

    risc18_prog_loader #(
        .SLOTS      (SLOTS),
        .RUN_CYCLES (RC),
        .PAD_WORD   (PAD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_last    (in_last),
        .core_pc    (core_pc),
        .core_reset (core_reset),
        .core_ans   (core_ans),
        .core_k     (core_k),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_ans    (res_ans),
        .res_k      (res_k),
        .res_err    (res_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 16'h0;
    always @(posedge clock) cyc <= cyc + 16'h1;
    assign core_ans = cyc;

    task automatic send_words(input int n, input logic [63:0] words, input bit use_last,
                              input bit keep_valid, output logic [63:0] exp_pc);
        logic [15:0] w;
        exp_pc = PAD_ALL;
        for (int i = 0; i < n; i++) begin
            w = words[63-16*i -: 16];
            exp_pc[63-16*i -: 16] = w;
            @(negedge clock);
            in_valid = 1'b1;
            in_instr = w;
            in_last  = use_last && (i == n - 1);
            for (int t = 0; t < 50 && !in_ready; t++) @(negedge clock);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL accept_wait: in_ready=%b required 1 within 50 cycles", in_ready);
            end
            @(posedge clock);
        end
        #1;
        if (keep_valid) begin
            in_instr = 16'hBEEF;
            in_last  = 1'b1;
        end else begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Call right after the edge that accepted the final word; returns at the negedge in RESULT.
    task automatic run_and_check(input logic [63:0] exp_pc, input logic [63:0] mask,
                                 input bit hold_valid, input bit pre_ready);
        res_t e;
        @(negedge clock);
        if (!hold_valid) in_valid = 1'b0;
        n_tests++;
        if (core_pc !== exp_pc) begin
            n_fail++;
            $display("FAIL core_pc: got %h required %h", core_pc, exp_pc);
        end
        n_tests++;
        if (core_reset !== 1'b1 || in_ready !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL core_rst_phase: core_reset=%b in_ready=%b res_valid=%b required 1 0 0",
                     core_reset, in_ready, res_valid);
        end
        core_k = exp_pc ^ mask;
        e.ans  = cyc + 16'(RC);
        e.k    = exp_pc ^ mask;
        e.err  = (mask != 64'h0);
        sb.push_back(e);
        if (pre_ready) res_ready = 1'b1;
        for (int r = 0; r < RC; r++) begin
            @(negedge clock);
            n_tests++;
            if (core_reset !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0 || core_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL run_phase[%0d]: core_reset=%b res_valid=%b in_ready=%b core_pc=%h required 0 0 0 %h",
                         r, core_reset, res_valid, in_ready, core_pc, exp_pc);
            end
        end
        @(negedge clock);
        n_tests++;
        if (res_valid !== 1'b1 || core_reset !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL result_entry: res_valid=%b core_reset=%b in_ready=%b required 1 1 0",
                     res_valid, core_reset, in_ready);
        end
    endtask

    // Call at the negedge where RESULT is visible; stalls for 'hold' cycles then consumes.
    task automatic collect(input int hold);
        res_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: queue empty, required one pending result");
            e.ans = '0; e.k = '0; e.err = 1'b0;
        end else begin
            e = sb.pop_front();
        end
        n_tests++;
        if (res_ans !== e.ans || res_k !== e.k || res_err !== e.err) begin
            n_fail++;
            $display("FAIL result_data: ans=%h k=%h err=%b required %h %h %b",
                     res_ans, res_k, res_err, e.ans, e.k, e.err);
        end
        for (int h = 0; h < hold; h++) begin
            core_k = ~core_k;
            @(negedge clock);
            n_tests++;
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_ans !== e.ans || res_k !== e.k || res_err !== e.err) begin
                n_fail++;
                $display("FAIL result_hold[%0d]: valid=%b in_ready=%b ans=%h k=%h err=%b required 1 0 %h %h %b",
                         h, res_valid, in_ready, res_ans, res_k, res_err, e.ans, e.k, e.err);
            end
        end
        res_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        res_ready = 1'b0;
        n_tests++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || core_reset !== 1'b1 || core_pc !== PAD_ALL) begin
            n_fail++;
            $display("FAIL result_exit: valid=%b in_ready=%b core_reset=%b core_pc=%h required 0 1 1 %h",
                     res_valid, in_ready, core_reset, core_pc, PAD_ALL);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_last = 1'b0;
        res_ready = 1'b0; core_k = '0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_tests++;
        if (in_ready !== 1'b1 || core_reset !== 1'b1 || core_pc !== 64'h0 || res_valid !== 1'b0 ||
            res_ans !== 16'h0 || res_k !== 64'h0 || res_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b crst=%b pc=%h rv=%b ans=%h k=%h err=%b required 1 1 0 0 0 0 0",
                     in_ready, core_reset, core_pc, res_valid, res_ans, res_k, res_err);
        end
    endtask

    task automatic test_full_program();
        logic [63:0] p;
        send_words(4, 64'h0101_5600_0211_0000, 1'b1, 1'b0, p);
        n_tests++;
        if (p !== 64'h0101_5600_0211_0000) begin
            n_fail++;
            $display("FAIL full_expect: built %h required 0101560002110000", p);
        end
        run_and_check(p, 64'h0, 1'b0, 1'b0);
        collect(0);
    endtask

    task automatic test_single_word();
        logic [63:0] p;
        send_words(1, 64'h1111_0000_0000_0000, 1'b1, 1'b0, p);
        run_and_check(64'h1111_0000_0000_0000, 64'h0, 1'b0, 1'b0);
        collect(0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] p;
        send_words(4, 64'h1010_1010_1010_1010, 1'b0, 1'b1, p);
        run_and_check(64'h1010_1010_1010_1010, 64'h0, 1'b1, 1'b0);
        collect(10);
        @(posedge clock);
        run_and_check(64'hBEEF_0000_0000_0000, 64'h0, 1'b0, 1'b0);
        collect(0);
    endtask

    task automatic test_ready_early();
        logic [63:0] p;
        send_words(3, 64'h2222_3333_4444_0000, 1'b1, 1'b0, p);
        run_and_check(64'h2222_3333_4444_0000, 64'h0, 1'b0, 1'b1);
        collect(0);
    endtask

    task automatic test_err();
        logic [63:0] p;
        send_words(4, 64'hA5A5_0F0F_1234_8001, 1'b1, 1'b0, p);
        run_and_check(p, 64'h0000_0100_0000_0001, 1'b0, 1'b0);
        collect(2);
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] p;
        send_words(4, 64'h7777_6666_5555_4444, 1'b1, 1'b0, p);
        @(negedge clock);
        core_k = p;
        repeat (2) @(negedge clock);
        n_tests++;
        if (core_reset !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_abort_run: core_reset=%b required 0", core_reset);
        end
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || core_reset !== 1'b1 || core_pc !== 64'h0 || res_valid !== 1'b0 ||
            res_ans !== 16'h0 || res_k !== 64'h0 || res_err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state: rdy=%b crst=%b pc=%h rv=%b ans=%h k=%h err=%b required 1 1 0 0 0 0 0",
                     in_ready, core_reset, core_pc, res_valid, res_ans, res_k, res_err);
        end
        @(negedge clock);
        reset = 1'b1;
        send_words(4, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, p);
        run_and_check(64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 1'b0);
        collect(1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_full_program();
        test_single_word();
        test_back_to_back();
        test_ready_early();
        test_err();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
